// File: rtl/rr_hold_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time per owner.
// An owner is pre-empted after MAX_HOLD consecutive cycles, but only when another requester is waiting.
module rr_hold_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       expire
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [HW-1:0] hold_q;
    logic [3:0]    grant_q;
    logic [1:0]    gid_q;
    logic          busy_q;
    logic          expire_q;

    logic [3:0]    others;
    logic [1:0]    win_idle;
    logic [1:0]    win_own;

    // First set bit of r, scanning upward from start and wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign others   = req & ~grant_q;
    assign win_idle = pick(req, ptr_q);
    assign win_own  = pick(others, gid_q + 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            hold_q   <= '0;
            grant_q  <= 4'b0000;
            gid_q    <= 2'd0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= OWNED;
                        grant_q <= 4'b0001 << win_idle;
                        gid_q   <= win_idle;
                        busy_q  <= 1'b1;
                        ptr_q   <= win_idle + 2'd1;
                        hold_q  <= HOLD_ONE;
                    end
                end
                OWNED: begin
                    if (!req[gid_q]) begin
                        if (|others) begin
                            // Direct hand-off: no idle bubble between owners.
                            grant_q <= 4'b0001 << win_own;
                            gid_q   <= win_own;
                            ptr_q   <= win_own + 2'd1;
                            hold_q  <= HOLD_ONE;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 4'b0000;
                            gid_q   <= 2'd0;
                            busy_q  <= 1'b0;
                            hold_q  <= '0;
                        end
                    end else if (hold_q == HOLD_MAX && (|others)) begin
                        grant_q  <= 4'b0001 << win_own;
                        gid_q    <= win_own;
                        ptr_q    <= win_own + 2'd1;
                        hold_q   <= HOLD_ONE;
                        expire_q <= 1'b1;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
    assign expire   = expire_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (MAX_HOLD = 8) with hand-computed expected outputs.
module tb_rr_hold_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       expire;

    int vectors;
    int miscompares;

    rr_hold_arbiter #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .expire   (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic b, input logic e);
        check({tag, ".grant"}, grant, g);
        check({tag, ".grant_id"}, {2'b00, grant_id}, {2'b00, id});
        check({tag, ".busy"}, {3'b000, busy}, {3'b000, b});
        check({tag, ".expire"}, {3'b000, expire}, {3'b000, e});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eg;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        req = 4'b1111;

        // Reset held with all requests asserted.
        step();
        step();
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        rst = 1'b1;
        step();
        check_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Remaining 7 cycles of owner 0, then rotation 1,2,3,0 with 8 cycles each.
        for (int c = 1; c < 8; c++) begin
            step();
            check_all("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                eg = 4'b0001 << (k % 4);
                check_all($sformatf("rot%0d_c%0d", k, c), eg, 2'(k % 4), 1'b1, (c == 0));
            end
        end

        // Owner 0 releases, only requester 3 remains and holds for 20 cycles.
        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            check_all($sformatf("solo3_c%0d", c), 4'b1000, 2'd3, 1'b1, 1'b0);
        end

        req = 4'b0000;
        step();
        check_all("all_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        check_all("idle_stay", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 0 hands directly to 2, then pointer 3 wins over 0 and 1.
        req = 4'b0001;
        step();
        check_all("own0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0100;
        step();
        check_all("handoff2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1011;
        step();
        check_all("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);

        req = 4'b0010;
        step();
        check_all("own1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset between edges drops the grant immediately.
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0110;
        step();
        check_all("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_all("restart", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive cycles one requester keeps the grant while others wait (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port req  input  4  per-requester request level; bit i high = requester i wants the resource.
REQ-005 The block SHALL have port grant  output  4  registered one-hot grant, or all-zero when idle.
REQ-006 The block SHALL have port grant_id  output  2  binary index of the current owner; 0 when idle.
REQ-007 The block SHALL have port busy  output  1  high whenever grant is non-zero.
REQ-008 The block SHALL have port expire  output  1  one-cycle pulse marking a forced pre-emption.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no owner) and OWNED (one owner i).
REQ-010 The block SHALL keep a 2-bit priority pointer ptr and search requesters in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
REQ-011 When a winner w is granted, the block SHALL set ptr to (w+1) mod 4 on the same edge.
REQ-012 In IDLE, if req is non-zero at an edge, the block SHALL assert grant for the winner after that edge, enter OWNED and load hold_cnt = 1. Latency is exactly one clock from req to grant.
REQ-013 In IDLE with req = 0, the block SHALL hold grant = 0 and busy = 0.
REQ-014 In OWNED, if req[i] = 0 at an edge and any other request is set, the block SHALL hand the grant directly to the winner searched from (i+1) mod 4 on that edge, with no idle bubble, and load hold_cnt = 1.
REQ-015 In OWNED, if req[i] = 0 and no other request is set, the block SHALL return to IDLE with grant = 0 after that edge.
REQ-016 In OWNED, if req[i] = 1, hold_cnt = MAX_HOLD and another request is set, the block SHALL pre-empt: grant the winner searched from (i+1) mod 4, load hold_cnt = 1, and assert expire for exactly that following cycle.
REQ-017 In OWNED, if req[i] = 1 and no other request is set, the block SHALL keep the grant, saturate hold_cnt at MAX_HOLD, and never assert expire.
REQ-018 In OWNED, if req[i] = 1 and hold_cnt < MAX_HOLD, the block SHALL keep the grant and increment hold_cnt.
REQ-019 The block SHALL size hold_cnt as ceil(log2(MAX_HOLD+1)) bits; it SHALL never wrap.
REQ-020 The block SHALL register grant, grant_id, busy and expire, and SHALL keep them mutually consistent in every cycle.
REQ-021 The block SHALL never assert more than one grant bit, and SHALL never grant a requester whose req bit was low at the deciding edge.
REQ-022 A new request arriving on the same edge the owner drops SHALL be eligible in that edge's search.

Reset
REQ-023 While rst = 0, the block SHALL force the following immediately, without waiting for a clock: grant = 0, grant_id = 0, busy = 0, expire = 0, ptr = 0, hold_cnt = 0, state IDLE.
REQ-024 Reset asserted mid-grant SHALL drop the grant at once. After release, arbitration SHALL restart from ptr = 0 at the first rising edge where rst = 1.

Verification
REQ-025 rst low with req = 1111 -> grant = 0000. First edge after release -> grant = 0001, grant_id = 0, busy = 1.
REQ-026 req = 1111 held, MAX_HOLD = 8 -> grant 0001 for 8 cycles, then 0010 with expire = 1 for one cycle, then 0100, 1000, 0001, each 8 cycles.
REQ-027 Only req = 1000 held for 20 cycles -> grant = 1000 throughout, grant_id = 3, expire never asserted.
REQ-028 Owner 0 drops req while req[2] = 1 -> next edge grant = 0100 with no zero cycle, and ptr = 3 (check by then raising req = 1011 -> winner 3).
REQ-029 rst pulsed low between clock edges while grant = 0010 -> grant = 0000 before the next edge. After release with req = 0110 -> grant = 0010.
REQ-030 All req drop to 0 while owned -> next edge grant = 0000, busy = 0, expire = 0.
